dmem_arbiter: RTL and testbench

- Two-requester arbiter sharing the single data-memory/IO bus port between the core load/store path (m0) and a program-loader/debug master (m1).
- Sits between the datapath LSU and the data memory plus IO-mapped peripheral block (switches, LEDs, LCD, hex).
- Round-robin arbitration, req/ack handshake per master, fixed-latency memory timing handled by an internal FSM.

---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/dmem_arbiter_if.sv | 47 ++++
 rtl/arb_rr2.sv | 22 ++
 rtl/dmem_arbiter.sv | 145 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_M0 = 1'b0,
        GNT_M1 = 1'b1
    } gnt_id_t;

    localparam int MEM_LAT_MAX = 7;
    localparam int CNT_W       = 3;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// The arbiter connects through the slave modport; the environment drives
// the master side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  i_m0_req;
    logic                  i_m0_we;
    logic [ADDR_W-1:0]     i_m0_addr;
    logic [DATA_W-1:0]     i_m0_wdata;
    logic [DATA_W/8-1:0]   i_m0_bmask;
    logic                  o_m0_ack;

    logic                  i_m1_req;
    logic                  i_m1_we;
    logic [ADDR_W-1:0]     i_m1_addr;
    logic [DATA_W-1:0]     i_m1_wdata;
    logic [DATA_W/8-1:0]   i_m1_bmask;
    logic                  o_m1_ack;

    logic [DATA_W-1:0]     o_rdata;

    logic                  o_mem_en;
    logic                  o_mem_we;
    logic [ADDR_W-1:0]     o_mem_addr;
    logic [DATA_W-1:0]     o_mem_wdata;
    logic [DATA_W/8-1:0]   o_mem_bmask;
    logic [DATA_W-1:0]     i_mem_rdata;

    modport slave (
        input  i_m0_req, i_m0_we, i_m0_addr, i_m0_wdata, i_m0_bmask,
        input  i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata, i_m1_bmask,
        input  i_mem_rdata,
        output o_m0_ack, o_m1_ack, o_rdata,
        output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask
    );

    modport master (
        output i_m0_req, i_m0_we, i_m0_addr, i_m0_wdata, i_m0_bmask,
        output i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata, i_m1_bmask,
        output i_mem_rdata,
        input  o_m0_ack, o_m1_ack, o_rdata,
        input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask
    );

endinterface

// File: rtl/arb_rr2.sv
// Combinational 2-way round-robin picker. Lock forces m1 to win and masks m0.
module arb_rr2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  gnt_id_t    ptr_i,
    input  logic       lock_i,
    output logic [1:0] gnt_o
);

    // One-hot grant: single requester wins outright, contention goes to ptr.
    always_comb begin
        gnt_o = 2'b00;
        if (lock_i)
            gnt_o = {req_i[1], 1'b0};
        else if (&req_i)
            gnt_o = (ptr_i == GNT_M1) ? 2'b10 : 2'b01;
        else
            gnt_o = req_i;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory/IO port between the core LSU
// (m0) and the loader/debug master (m1). Fixed-latency memory timing is
// sequenced by a 4-state FSM. Optional m1 lock: define DMEM_ARB_LOCK_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
)(
    input  logic            i_clk,
    input  logic            i_reset,
`ifdef DMEM_ARB_LOCK_EN
    input  logic            i_m1_lock,
`endif
    dmem_arbiter_if.slave   bus
);

    localparam int LAT_EFF = (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LAT_EFF - 1);

    arb_state_t          state_q, state_d;
    gnt_id_t             ptr_q, ptr_d;
    gnt_id_t             id_q, id_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] bmask_q, bmask_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [1:0]          req, gnt;
    logic                lock;
    logic                mem_en, ack;
    logic [DATA_W-1:0]   rdata;

`ifdef DMEM_ARB_LOCK_EN
    assign lock = i_m1_lock;
`else
    assign lock = 1'b0;
`endif

    assign req = {bus.i_m1_req, bus.i_m0_req};

    arb_rr2 u_rr (
        .req_i  (req),
        .ptr_i  (ptr_q),
        .lock_i (lock),
        .gnt_o  (gnt)
    );

    // State and latched transaction attributes.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            ptr_q   <= GNT_M0;
            id_q    <= GNT_M0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            bmask_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            bmask_q <= bmask_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, grant latching and per-state strobes.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        bmask_d = bmask_q;
        cnt_d   = cnt_q;
        mem_en  = 1'b0;
        ack     = 1'b0;
        rdata   = '0;
        case (state_q)
            IDLE: begin
                if (gnt[1]) begin
                    id_d    = GNT_M1;
                    we_d    = bus.i_m1_we;
                    addr_d  = bus.i_m1_addr;
                    wdata_d = bus.i_m1_wdata;
                    bmask_d = bus.i_m1_bmask;
                    state_d = ACCESS;
                end else if (gnt[0]) begin
                    id_d    = GNT_M0;
                    we_d    = bus.i_m0_we;
                    addr_d  = bus.i_m0_addr;
                    wdata_d = bus.i_m0_wdata;
                    bmask_d = bus.i_m0_bmask;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                mem_en = 1'b1;
                if (we_q) begin
                    // Writes complete on the strobe cycle itself.
                    ack     = 1'b1;
                    ptr_d   = (id_q == GNT_M0) ? GNT_M1 : GNT_M0;
                    state_d = IDLE;
                end else if (LAT_EFF <= 1) begin
                    state_d = RESP;
                end else begin
                    cnt_d   = LAT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Leave when the counter steps to zero so RESP lands MEM_LAT
                // cycles after the strobe.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1))
                    state_d = RESP;
            end
            RESP: begin
                rdata   = bus.i_mem_rdata;
                ack     = 1'b1;
                ptr_d   = (id_q == GNT_M0) ? GNT_M1 : GNT_M0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.o_mem_en    = mem_en;
    assign bus.o_mem_we    = mem_en & we_q;
    assign bus.o_mem_addr  = mem_en ? addr_q  : '0;
    assign bus.o_mem_wdata = mem_en ? wdata_q : '0;
    assign bus.o_mem_bmask = mem_en ? bmask_q : '0;
    assign bus.o_rdata     = rdata;
    assign bus.o_m0_ack    = ack & (id_q == GNT_M0);
    assign bus.o_m1_ack    = ack & (id_q == GNT_M1);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with MEM_LAT=3. Stimulus pushes the
// expected memory strobes and acks; a negedge monitor pops and compares.
// Lock scenario is built only when DMEM_ARB_LOCK_EN is defined.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int L = 3;

    logic i_clk   = 1'b0;
    logic i_reset = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
    logic i_m1_lock = 1'b0;
`endif

    always #5 i_clk = ~i_clk;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
`ifdef DMEM_ARB_LOCK_EN
        .i_m1_lock (i_m1_lock),
`endif
        .bus       (bus.slave)
    );

    typedef struct {
        int          id;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bmask;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t memq[$];
    exp_t ackq[$];

    int cyc       = 0;
    int n_chk     = 0;
    int n_fail    = 0;
    int acks_seen = 0;

    // Read-only memory model: data for the strobed address appears the
    // cycle after the strobe and holds until the next read.
    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_q = 32'h0;
    assign bus.i_mem_rdata = rd_q;

    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        if (bus.o_mem_en && !bus.o_mem_we)
            rd_q <= mem.exists(bus.o_mem_addr) ? mem[bus.o_mem_addr] : ~bus.o_mem_addr;
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: compare every output each cycle against the scoreboard.
    always @(negedge i_clk) begin
        exp_t e;
        if (!i_reset) begin
            chk("reset_outputs", {bus.o_mem_en, bus.o_mem_we, bus.o_m0_ack, bus.o_m1_ack,
                                  |bus.o_mem_addr, |bus.o_mem_wdata, |bus.o_mem_bmask, |bus.o_rdata}, 64'h0);
        end else begin
            chk("ack_exclusive", {63'h0, bus.o_m0_ack & bus.o_m1_ack}, 64'h0);
            if (bus.o_mem_en) begin
                if (memq.size() == 0) begin
                    chk("mem_unexpected_strobe", 64'h1, 64'h0);
                end else begin
                    e = memq.pop_front();
                    chk("mem_cycle", 64'(cyc),            64'(e.cyc));
                    chk("mem_we",    64'(bus.o_mem_we),   64'(e.we));
                    chk("mem_addr",  64'(bus.o_mem_addr), 64'(e.addr));
                    chk("mem_wdata", 64'(bus.o_mem_wdata),64'(e.wdata));
                    chk("mem_bmask", 64'(bus.o_mem_bmask),64'(e.bmask));
                end
            end else begin
                chk("mem_idle_zero", {bus.o_mem_we, |bus.o_mem_addr, |bus.o_mem_wdata, |bus.o_mem_bmask}, 64'h0);
            end
            if (bus.o_m0_ack || bus.o_m1_ack) begin
                acks_seen++;
                if (ackq.size() == 0) begin
                    chk("ack_unexpected", 64'h1, 64'h0);
                end else begin
                    e = ackq.pop_front();
                    chk("ack_id",    64'(bus.o_m1_ack), 64'(e.id));
                    chk("ack_cycle", 64'(cyc),          64'(e.cyc));
                    chk("ack_rdata", 64'(bus.o_rdata),  e.we ? 64'h0 : 64'(e.rdata));
                end
            end else begin
                chk("rdata_idle_zero", 64'(bus.o_rdata), 64'h0);
            end
        end
    end

    task automatic drive(input int m, input logic req, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] bm);
        if (m == 0) begin
            bus.i_m0_req = req; bus.i_m0_we = we; bus.i_m0_addr = a;
            bus.i_m0_wdata = wd; bus.i_m0_bmask = bm;
        end else begin
            bus.i_m1_req = req; bus.i_m1_we = we; bus.i_m1_addr = a;
            bus.i_m1_wdata = wd; bus.i_m1_bmask = bm;
        end
    endtask

    task automatic push(input int m, input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] bm, input logic [31:0] rd, input int en_cyc,
                        input int ack_cyc, input bit with_ack);
        exp_t e;
        e.id = m; e.we = we; e.addr = a; e.wdata = wd; e.bmask = bm; e.rdata = rd;
        e.cyc = en_cyc;
        memq.push_back(e);
        if (with_ack) begin
            e.cyc = ack_cyc;
            ackq.push_back(e);
        end
    endtask

    task automatic wait_acks(input int target, input string name);
        int n = 0;
        while (acks_seen < target && n < 60) begin
            @(negedge i_clk); #1;
            n++;
        end
        n_chk++;
        if (acks_seen < target) begin
            n_fail++;
            $display("FAIL %s: timed out with %0d acks, expected %0d", name, acks_seen, target);
        end
    endtask

    // One request from a single master; ack_off is the hand-computed ack
    // cycle relative to the IDLE cycle N in which req is first seen.
    task automatic single(input int m, input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] bm, input logic [31:0] rd, input int ack_off,
                          input bit drop_early, input string name);
        int c0, tgt;
        @(posedge i_clk); #2;
        c0  = cyc;
        tgt = acks_seen + 1;
        push(m, we, a, wd, bm, rd, c0 + 1, c0 + ack_off, 1'b1);
        drive(m, 1'b1, we, a, wd, bm);
        if (drop_early) begin
            @(posedge i_clk); #2;
            drive(m, 1'b0, ~we, ~a, ~wd, ~bm);
        end
        wait_acks(tgt, name);
        @(posedge i_clk); #2;
        drive(m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        int c0, tgt;
        mem[32'h20] = 32'h1234_5678;
        mem[32'h30] = 32'hA0A0_0030;
        mem[32'h40] = 32'hB0B0_0040;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(posedge i_clk);
        #2 i_reset = 1'b1;

        // m0 write: strobe and ack both in N+1.
        single(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1, 1'b0, "t1_m0_write");
        // m1 read, latency 3: ack and data at N+4.
        single(1, 1'b0, 32'h20, 32'h0, 4'hF, 32'h1234_5678, 4, 1'b0, "t2_m1_read");

        // Both hold reads: m0,m1,m0,m1, 5 cycles per transaction.
        @(posedge i_clk); #2;
        c0  = cyc;
        tgt = acks_seen + 4;
        push(0, 1'b0, 32'h30, 32'h0, 4'hF, 32'hA0A0_0030, c0 + 1,  c0 + 4,  1'b1);
        push(1, 1'b0, 32'h40, 32'h0, 4'hF, 32'hB0B0_0040, c0 + 6,  c0 + 9,  1'b1);
        push(0, 1'b0, 32'h30, 32'h0, 4'hF, 32'hA0A0_0030, c0 + 11, c0 + 14, 1'b1);
        push(1, 1'b0, 32'h40, 32'h0, 4'hF, 32'hB0B0_0040, c0 + 16, c0 + 19, 1'b1);
        drive(0, 1'b1, 1'b0, 32'h30, 32'h0, 4'hF);
        drive(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
        wait_acks(tgt, "t3_contend_reads");
        @(posedge i_clk); #2;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // m0 write whose req and attributes change right after grant.
        single(0, 1'b1, 32'h14, 32'hCAFE_F00D, 4'h5, 32'h0, 1, 1'b1, "t4_drop_after_grant");

        // m1 read abandoned by reset in WAIT: strobe seen, no ack.
        @(posedge i_clk); #2;
        c0 = cyc;
        push(1, 1'b0, 32'h50, 32'h0, 4'hF, 32'h0, c0 + 1, 0, 1'b0);
        drive(1, 1'b1, 1'b0, 32'h50, 32'h0, 4'hF);
        @(posedge i_clk); #2;
        @(posedge i_clk); #2;
        i_reset = 1'b0;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (2) @(posedge i_clk);
        #2 i_reset = 1'b1;

        // Contention after reset: pointer is back at m0.
        @(posedge i_clk); #2;
        c0  = cyc;
        tgt = acks_seen + 2;
        push(0, 1'b1, 32'h60, 32'h0000_6060, 4'h3, 32'h0, c0 + 1, c0 + 1, 1'b1);
        push(1, 1'b1, 32'h70, 32'h7070_0000, 4'hC, 32'h0, c0 + 3, c0 + 3, 1'b1);
        drive(0, 1'b1, 1'b1, 32'h60, 32'h0000_6060, 4'h3);
        drive(1, 1'b1, 1'b1, 32'h70, 32'h7070_0000, 4'hC);
        wait_acks(tgt, "t5_post_reset_contend");
        @(posedge i_clk); #2;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

`ifdef DMEM_ARB_LOCK_EN
        // Lock: four m1 writes despite the pointer favouring m0, then m0.
        @(posedge i_clk); #2;
        c0  = cyc;
        tgt = acks_seen + 4;
        i_m1_lock = 1'b1;
        push(1, 1'b1, 32'h90, 32'h9999_0000, 4'hF, 32'h0, c0 + 1, c0 + 1, 1'b1);
        push(1, 1'b1, 32'h90, 32'h9999_0000, 4'hF, 32'h0, c0 + 3, c0 + 3, 1'b1);
        push(1, 1'b1, 32'h90, 32'h9999_0000, 4'hF, 32'h0, c0 + 5, c0 + 5, 1'b1);
        push(1, 1'b1, 32'h90, 32'h9999_0000, 4'hF, 32'h0, c0 + 7, c0 + 7, 1'b1);
        push(0, 1'b1, 32'h80, 32'h0000_8888, 4'hF, 32'h0, c0 + 9, c0 + 9, 1'b1);
        drive(0, 1'b1, 1'b1, 32'h80, 32'h0000_8888, 4'hF);
        drive(1, 1'b1, 1'b1, 32'h90, 32'h9999_0000, 4'hF);
        wait_acks(tgt, "t6_lock_burst");
        @(posedge i_clk); #2;
        i_m1_lock = 1'b0;
        wait_acks(tgt + 1, "t6_lock_release");
        @(posedge i_clk); #2;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
`endif

        repeat (6) @(posedge i_clk);
        @(negedge i_clk); #1;
        chk("memq_drained", 64'(memq.size()), 64'h0);
        chk("ackq_drained", 64'(ackq.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
